// File: rtl/rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_pkg
// Description : Shared constants and types for the recursive-doubling
//               subtractor (and its companion adder).
// Revision    : 1.0  initial release
// ============================================================================
package rd_pkg;

  localparam int RD_WIDTH  = 8;
  localparam int RD_LEVELS = 3;
  // Input register + one register per prefix level + output register.
  localparam int RD_LAT    = RD_LEVELS + 2;

  // Per-stage generate/propagate vector pair.
  typedef struct packed {
    logic [RD_WIDTH-1:0] g;
    logic [RD_WIDTH-1:0] p;
  } rd_gp_t;

endpackage
`default_nettype wire

// File: rtl/rd_prefix_cell.sv
`default_nettype none
// ============================================================================
// Module      : rd_prefix_cell
// Description : Combinational black cell of a generate/propagate prefix tree:
//               merges a high group (g_hi, p_hi) with the adjacent lower group
//               (g_lo, p_lo).
// Revision    : 1.0  initial release
// ============================================================================
module rd_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule
`default_nettype wire

// File: rtl/rd_sub8p.sv
`default_nettype none
// ============================================================================
// Module      : rd_sub8p
// Description : Pipelined recursive-doubling subtractor, diff = a - b with
//               unsigned borrow. Input register, one prefix level per stage,
//               registered output; a valid bit rides along and en freezes
//               the whole pipe.
//               Optional: define RD_SUB_OVF_EN to add the signed-overflow
//               output ovf.
// Revision    : 1.0  initial release
// ============================================================================
module rd_sub8p
  import rd_pkg::*;
#(
  parameter int WIDTH = RD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef RD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // Stage S0: registered operands
  logic [WIDTH-1:0]            r_a;
  logic [WIDTH-1:0]            r_b;
  // Valid chain: bit 0 = S0, bit LEVELS+1 = output stage
  logic [LEVELS+1:0]           r_v;

  // Bit-level g/p formed from the S0 registers (carry-in folded into bit 0)
  logic [WIDTH-1:0]            w_g0;
  logic [WIDTH-1:0]            w_p0;

  // Prefix-level registers (S1..S<LEVELS>) and the pipelined bit propagate
  logic [LEVELS:1][WIDTH-1:0]  r_g;
  logic [LEVELS:1][WIDTH-1:0]  r_p;
  logic [LEVELS:1][WIDTH-1:0]  r_pb;

  // Source of each level (level k reads w_sg[k-1]) and its combinational result
  logic [LEVELS-1:0][WIDTH-1:0] w_sg;
  logic [LEVELS-1:0][WIDTH-1:0] w_sp;
  logic [LEVELS:1][WIDTH-1:0]   w_ng;
  logic [LEVELS:1][WIDTH-1:0]   w_np;

  // Output stage
  logic [WIDTH-1:0]            r_diff;
  logic                        r_borrow;

  // The group propagate of the last level has no consumer.
  logic                        w_unused_p;
  assign w_unused_p = ^r_p[LEVELS];

  // a + ~b + 1: generate/propagate per bit; the +1 acts as a generate below bit 0
  always_comb begin
    w_g0    = r_a & ~r_b;
    w_p0    = r_a ^ ~r_b;
    w_g0[0] = w_g0[0] | w_p0[0];
  end

  // Route each level's input: level 1 from S0 logic, later levels from registers
  always_comb begin
    w_sg[0] = w_g0;
    w_sp[0] = w_p0;
    for (int k = 1; k < LEVELS; k++) begin
      w_sg[k] = r_g[k];
      w_sp[k] = r_p[k];
    end
  end

  // One recursive-doubling level per stage, distance 1, 2, 4, ...
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        rd_prefix_cell u_cell (
          .g_hi (w_sg[k-1][i]),
          .p_hi (w_sp[k-1][i]),
          .g_lo (w_sg[k-1][i-D]),
          .p_lo (w_sp[k-1][i-D]),
          .g    (w_ng[k][i]),
          .p    (w_np[k][i])
        );
      end else begin : g_pass
        assign w_ng[k][i] = w_sg[k-1][i];
        assign w_np[k][i] = w_sp[k-1][i];
      end
    end
  end

  // Pipeline registers: reset clears everything, en=0 freezes every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_v      <= '0;
      r_g      <= '0;
      r_p      <= '0;
      r_pb     <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (en) begin
      r_a <= a;
      r_b <= b;
      r_v <= {r_v[LEVELS:0], valid_in};
      for (int k = 1; k <= LEVELS; k++) begin
        r_g[k] <= w_ng[k];
        r_p[k] <= w_np[k];
      end
      r_pb[1] <= w_p0;
      for (int k = 2; k <= LEVELS; k++) begin
        r_pb[k] <= r_pb[k-1];
      end
      // Sum bit i is propagate xor carry into bit i; carry into bit 0 is 1.
      r_diff   <= {r_pb[LEVELS][WIDTH-1:1] ^ r_g[LEVELS][WIDTH-2:0], ~r_pb[LEVELS][0]};
      r_borrow <= ~r_g[LEVELS][WIDTH-1];
    end
  end

`ifdef RD_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (en) begin
      r_ovf <= r_g[LEVELS][WIDTH-2] ^ r_g[LEVELS][WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

  assign valid_out = r_v[LEVELS+1];
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_rd_sub8p.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_sub8p
// Description : Scoreboard bench for rd_sub8p. Expected results are queued
//               when an operation is accepted and retired when the pipe
//               delivers them; hold and reset behaviour are modelled too.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rd_sub8p;
  import rd_pkg::*;

  localparam int W = RD_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         valid_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid_out;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef RD_SUB_OVF_EN
  logic         ovf;
`endif

  rd_sub8p dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .diff      (diff),
    .borrow    (borrow)
`ifdef RD_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           cap;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: enabled-edge count and the output the pipe should show
  int           adv_cnt  = 0;
  bit           prev_adv = 1'b0;
  bit           prev_rst = 1'b1;
  logic         m_v      = 1'b0;
  logic [W-1:0] m_d      = '0;
  logic         m_b      = 1'b0;
  logic         m_o      = 1'b0;

  // Monitor/scoreboard: evaluate the edge just passed, then record what the next edge samples
  always @(negedge clk) begin
    if (prev_rst) begin
      sbq.delete();
      m_v = 1'b0; m_d = '0; m_b = 1'b0; m_o = 1'b0;
      check("rst_valid", valid_out, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
`ifdef RD_SUB_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
    end else if (prev_adv) begin
      adv_cnt++;
      if (sbq.size() > 0 && (adv_cnt - sbq[0].cap + 1) == RD_LAT) begin
        exp_t e;
        e   = sbq.pop_front();
        m_v = 1'b1; m_d = e.d; m_b = e.br; m_o = e.ov;
      end else begin
        m_v = 1'b0;
      end
      check("valid", valid_out, m_v);
      if (m_v) begin
        check("diff", diff, m_d);
        check("borrow", borrow, m_b);
`ifdef RD_SUB_OVF_EN
        check("ovf", ovf, m_o);
`endif
      end
    end else begin
      check("hold_valid", valid_out, m_v);
      if (m_v) begin
        check("hold_diff", diff, m_d);
        check("hold_borrow", borrow, m_b);
`ifdef RD_SUB_OVF_EN
        check("hold_ovf", ovf, m_o);
`endif
      end
    end

    prev_rst = reset;
    prev_adv = en && !reset;
    if (en && !reset && valid_in) begin
      exp_t e;
      e.d   = a - b;
      e.br  = (a < b);
      e.ov  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
      e.cap = adv_cnt + 1;
      sbq.push_back(e);
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit e = 1'b1, input bit r = 1'b0);
    @(posedge clk);
    #1;
    valid_in = v;
    a        = x;
    b        = y;
    en       = e;
    reset    = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b1;

    // Basic and borrow wrap
    drive(1, 8'd5, 8'd3);
    idle(6);
    drive(1, 8'd3, 8'd5);
    drive(1, 8'd0, 8'd1);
    idle(6);

    // Back-to-back stream
    drive(1, 8'd128, 8'd128);
    drive(1, 8'd255, 8'd0);
    drive(1, 8'd0, 8'd255);
    idle(6);

    // Hold: one enabled cycle after issue, then three frozen cycles with junk inputs
    drive(1, 8'd200, 8'd55);
    drive(0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) drive(1, 8'd9, 8'd77, 1'b0);
    idle(8);

    // Reset with three operations in flight
    drive(1, 8'd10, 8'd1);
    drive(1, 8'd20, 8'd2);
    drive(1, 8'd30, 8'd3);
    drive(1, 8'd40, 8'd4, 1'b1, 1'b1);
    idle(8);

    // Signed overflow corners
    drive(1, 8'd128, 8'd1);
    drive(1, 8'd127, 8'd255);
    drive(1, 8'd100, 8'd50);
    idle(6);

    // Random traffic with random stalls
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 4) != 0));
    end
    idle(10);

    check("drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
